// File: rtl/dpram_arb_pkg.sv
// Shared constants and state type for the dual-port RAM arbiter.
// The RAM is cleared two words per cycle, so the clear takes DEPTH/2 cycles.
package dpram_arb_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_AW     = 5;
  localparam int DEF_DW     = 8;
  localparam int DEPTH      = 32;
  localparam int CLR_CYCLES = DEPTH / 2;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/rr_first_pick.sv
// Circular first-set search over a request vector.
// The search starts at start_i and skips any index set in excl_i.
module rr_first_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  excl_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0]  cand;
  logic [IW-1:0] j;

  assign cand = req_i & ~excl_i;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(start_i) + k) % N);
      if (!found_o && cand[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing both ports of a 32x8 dual-port RAM.
// Clears the RAM after reset, then grants up to two requests per cycle.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  WE,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*DW-1:0] WDATA,
  output logic [NREQ-1:0]  GNT,
  output logic [NREQ-1:0]  RVALID,
  output logic [NREQ*DW-1:0] RDATA,
  output logic             INIT_DONE,
  output logic             WENA,
  output logic             WENB,
  output logic [AW-1:0]    AA,
  output logic [AW-1:0]    AB,
  output logic [DW-1:0]    DA,
  output logic [DW-1:0]    DB,
  input  logic [DW-1:0]    QA,
  input  logic [DW-1:0]    QB
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CLR_CYCLES);

  state_e          state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ-1:0] rd_port_q, rd_port_d;
  logic [NREQ*DW-1:0] rdata_q, rdata_d;

  logic            a_found, b_found, b_ok, hazard;
  logic [IW-1:0]   a_idx, b_idx;
  logic [NREQ-1:0] a_mask;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_wdata, b_wdata;
  logic            a_we, b_we;

  rr_first_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .req_i   (REQ),
    .start_i (ptr_q),
    .excl_i  ('0),
    .found_o (a_found),
    .idx_o   (a_idx)
  );

  assign a_mask = a_found ? (NREQ'(1) << a_idx) : '0;

  rr_first_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .req_i   (REQ),
    .start_i (ptr_q),
    .excl_i  (a_mask),
    .found_o (b_found),
    .idx_o   (b_idx)
  );

  assign a_addr  = ADDR[int'(a_idx)*AW +: AW];
  assign b_addr  = ADDR[int'(b_idx)*AW +: AW];
  assign a_wdata = WDATA[int'(a_idx)*DW +: DW];
  assign b_wdata = WDATA[int'(b_idx)*DW +: DW];
  assign a_we    = WE[a_idx];
  assign b_we    = WE[b_idx];

  // Same address with any write in the pair: B waits a cycle.
  assign hazard = a_found && b_found && (a_addr == b_addr) && (a_we || b_we);
  assign b_ok   = b_found && !hazard;

  assign INIT_DONE = (state_q == RUN);
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rdata_d[i*DW +: DW] = rdata_q[i*DW +: DW];
      if (rvalid_q[i])
        rdata_d[i*DW +: DW] = rd_port_q[i] ? QB : QA;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    rvalid_d  = '0;
    rd_port_d = '0;
    GNT       = '0;
    WENA      = 1'b0;
    WENB      = 1'b0;
    AA        = '0;
    AB        = '0;
    DA        = '0;
    DB        = '0;
    unique case (state_q)
      INIT: begin
        WENA      = 1'b1;
        WENB      = 1'b1;
        AA        = AW'({clr_cnt_q, 1'b0});
        AB        = AW'({clr_cnt_q, 1'b1});
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CW'(CLR_CYCLES - 1))
          state_d = RUN;
      end
      RUN: begin
        if (a_found) begin
          GNT[a_idx]      = 1'b1;
          WENA            = a_we;
          AA              = a_addr;
          DA              = a_we ? a_wdata : '0;
          rvalid_d[a_idx] = ~a_we;
          ptr_d = IW'((int'(a_idx) + 1) % NREQ);
        end
        if (b_ok) begin
          GNT[b_idx]       = 1'b1;
          WENB             = b_we;
          AB               = b_addr;
          DB               = b_we ? b_wdata : '0;
          rvalid_d[b_idx]  = ~b_we;
          rd_port_d[b_idx] = 1'b1;
          ptr_d = IW'((int'(b_idx) + 1) % NREQ);
        end
      end
      default: ;
    endcase
    if (RST) begin
      GNT  = '0;
      WENA = 1'b0;
      WENB = 1'b0;
      AA   = '0;
      AB   = '0;
      DA   = '0;
      DB   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      rvalid_q  <= '0;
      rd_port_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      rvalid_q  <= rvalid_d;
      rd_port_q <= rd_port_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM.
module tb_dpram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             preload;
  logic [NREQ-1:0]  req, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]  gnt, rvalid;
  logic [NREQ*DW-1:0] rdata;
  logic             init_done, wena, wenb;
  logic [AW-1:0]    aa, ab;
  logic [DW-1:0]    da, db, qa, qb;
  logic [DW-1:0]    mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .WE(we), .ADDR(addr),
    .WDATA(wdata), .GNT(gnt), .RVALID(rvalid), .RDATA(rdata),
    .INIT_DONE(init_done), .WENA(wena), .WENB(wenb),
    .AA(aa), .AB(ab), .DA(da), .DB(db), .QA(qa), .QB(qb)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hFF;
    end else begin
      if (wena) mem[aa] <= da;
      if (wenb) mem[ab] <= db;
    end
    qa <= mem[aa];
    qb <= mem[ab];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  task automatic run_clear();
    for (int i = 0; i < 16; i++) begin
      chk("init_done_lo", init_done, 0);
      chk("init_gnt", gnt, 0);
      chk("init_wen", {wena, wenb}, 2'b11);
      chk("init_aa", aa, 2 * i);
      chk("init_ab", ab, 2 * i + 1);
      step();
    end
    chk("init_done_hi", init_done, 1);
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ports", {wena, wenb, aa, ab, da, db}, 0);
    rst = 1'b0; preload = 1'b0;
    req = 4'b0001;
    #1;
    run_clear();
    req = '0;

    // round-robin, all reading
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    req = 4'b1111;
    #1 chk("rr_g1", gnt, 4'b0011);
    step(); chk("rr_g2", gnt, 4'b1100); chk("rr_v2", rvalid, 4'b0011);
    step(); chk("rr_g3", gnt, 4'b0011); chk("rr_v3", rvalid, 4'b1100);
    step(); chk("rr_g4", gnt, 4'b1100); chk("rr_v4", rvalid, 4'b0011);
    step(); req = '0;
    #1 chk("rr_v5", rvalid, 4'b1100);

    // read back every address after the clear
    step();
    req = 4'b0011;
    for (int k = 0; k < 16; k++) begin
      set_req(0, 1'b0, AW'(2 * k), 8'h00);
      set_req(1, 1'b0, AW'(2 * k + 1), 8'h00);
      #1 chk("clr_gnt", gnt, 4'b0011);
      if (k > 0) begin
        chk("clr_rvalid", rvalid, 4'b0011);
        chk("clr_rd0", rd(0), 8'h00);
        chk("clr_rd1", rd(1), 8'h00);
      end
      step();
    end
    req = '0;
    #1 chk("clr_rvalid_last", rvalid, 4'b0011);
    chk("clr_rd_last", {rd(0), rd(1)}, 16'h0000);

    // write/read hazard on address 7, ptr=2
    step();
    set_req(0, 1'b1, 5'd7, 8'h5A);
    set_req(1, 1'b0, 5'd7, 8'h00);
    req = 4'b0011;
    #1 chk("haz_gnt1", gnt, 4'b0001);
    chk("haz_porta", {wena, aa, da}, {1'b1, 5'd7, 8'h5A});
    chk("haz_portb", {wenb, ab, db}, 0);
    step(); req = 4'b0010;
    #1 chk("haz_gnt2", gnt, 4'b0010);
    step(); req = '0;
    #1 chk("haz_rvalid", rvalid, 4'b0010);
    chk("haz_rdata1", rd(1), 8'h5A);

    // dual same-address read of address 12
    set_req(2, 1'b1, 5'd12, 8'h3C);
    req = 4'b0100;
    #1 chk("dual_wr_gnt", gnt, 4'b0100);
    step();
    set_req(2, 1'b0, 5'd12, 8'h00);
    set_req(3, 1'b0, 5'd12, 8'h00);
    req = 4'b1100;
    #1 chk("dual_gnt", gnt, 4'b1100);
    chk("dual_addr", {aa, ab}, {5'd12, 5'd12});
    step(); req = '0;
    #1 chk("dual_rvalid", rvalid, 4'b1100);
    chk("dual_rd2", rd(2), 8'h3C);
    chk("dual_rd3", rd(3), 8'h3C);

    // move ptr to 1, then write-write collision at 31
    set_req(0, 1'b0, 5'd0, 8'h00);
    req = 4'b0001;
    #1 chk("ptr_gnt0", gnt, 4'b0001);
    step();
    set_req(1, 1'b1, 5'd31, 8'h11);
    set_req(2, 1'b1, 5'd31, 8'h22);
    req = 4'b0110;
    #1 chk("ww_gnt1", gnt, 4'b0010);
    chk("ww_da", da, 8'h11);
    step(); req = 4'b0100;
    #1 chk("ww_gnt2", gnt, 4'b0100);
    step();
    set_req(0, 1'b0, 5'd31, 8'h00);
    req = 4'b0001;
    #1 chk("ww_rd_gnt", gnt, 4'b0001);
    step(); req = '0;
    #1 chk("ww_rvalid", rvalid, 4'b0001);
    chk("ww_rdata", rd(0), 8'h22);

    // reset right after a read grant, ptr=1
    set_req(1, 1'b0, 5'd12, 8'h00);
    req = 4'b0010;
    #1 chk("mid_gnt", gnt, 4'b0010);
    step(); req = '0; rst = 1'b1;
    step();
    chk("mid_rvalid", rvalid, 0);
    chk("mid_init_done", init_done, 0);
    chk("mid_ports", {wena, wenb}, 0);
    rst = 1'b0;
    #1;
    run_clear();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    set_req(0, 1'b0, 5'd7, 8'h00);
    req = 4'b1111;
    #1 chk("mid_ptr0_gnt", gnt, 4'b0011);
    step(); req = '0;
    #1 chk("mid_rvalid2", rvalid, 4'b0011);
    chk("mid_rd7", rd(0), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
